ex_muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage, fed by the ID/EX pipeline register outputs (`data1`, `data2`, `funct`, `RDaddr`). It accepts one M-extension operation at a time and computes it over multiple cycles. While computing it drives a stall request to the hazard unit, which freezes PC, IF/ID and ID/EX. It returns a 32-bit result with a one-cycle `done_o` pulse for the EX/MEM register.

---
 rtl/ex_muldiv_unit.sv | 168 ++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | ex_muldiv_unit: iterative RV32M multiply/divide unit for the EX stage   |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module ex_muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              flush_i,
   input  logic [9:0]        funct_i,
   input  logic [XLEN-1:0]   data1_i,
   input  logic [XLEN-1:0]   data2_i,
   input  logic [4:0]        RDaddr_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [XLEN-1:0]   result_o,
   output logic [4:0]        RDaddr_o
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

   state_e              state_q, state_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     opb_q, opb_d;
   logic [4:0]          cnt_q, cnt_d;
   logic [2:0]          op_q, op_d;
   logic [4:0]          rd_q, rd_d;
   logic                neg_res_q, neg_res_d;
   logic                neg_rem_q, neg_rem_d;
   logic [XLEN-1:0]     result_q, result_d;
   logic [4:0]          rdout_q, rdout_d;

   logic [2:0]          w_f3;
   logic                w_accept, w_s1, w_s2, w_neg1, w_neg2, w_div0, w_ovf;
   logic [XLEN-1:0]     w_mag1, w_mag2, w_min;
   logic [XLEN:0]       w_mul_sum, w_trial;
   logic [2*XLEN-1:0]   w_mul_next, w_div_next, w_prod_fix;
   logic [XLEN-1:0]     w_mul_res, w_div_res, w_quo, w_rem;

   assign w_f3     = funct_i[2:0];
   assign w_accept = start_i && (funct_i[9:3] == 7'b0000001) && !flush_i;
   assign w_s1     = (w_f3 == 3'b001) || (w_f3 == 3'b010) || (w_f3 == 3'b100) || (w_f3 == 3'b110);
   assign w_s2     = (w_f3 == 3'b001) || (w_f3 == 3'b100) || (w_f3 == 3'b110);
   assign w_neg1   = w_s1 && data1_i[XLEN-1];
   assign w_neg2   = w_s2 && data2_i[XLEN-1];
   assign w_mag1   = w_neg1 ? -data1_i : data1_i;
   assign w_mag2   = w_neg2 ? -data2_i : data2_i;
   assign w_min    = {1'b1, {(XLEN-1){1'b0}}};
   assign w_div0   = w_f3[2] && (data2_i == '0);
   assign w_ovf    = w_f3[2] && !w_f3[0] && (data1_i == w_min) && (data2_i == '1);

   // Multiply: high half accumulates, multiplier bits shift out of the low half.
   assign w_mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opb_q : {XLEN{1'b0}})};
   assign w_mul_next = {w_mul_sum, acc_q[XLEN-1:1]};

   // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
   assign w_trial    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, opb_q};
   assign w_div_next = w_trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                     : {w_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

   assign w_prod_fix = neg_res_q ? -w_mul_next : w_mul_next;
   assign w_mul_res  = (op_q == 3'b000) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];
   assign w_quo      = w_div_next[XLEN-1:0];
   assign w_rem      = w_div_next[2*XLEN-1:XLEN];
   assign w_div_res  = op_q[1] ? (neg_rem_q ? -w_rem : w_rem) : (neg_res_q ? -w_quo : w_quo);

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      opb_d     = opb_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      rd_d      = rd_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      rdout_d   = rdout_q;
      busy_o    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               busy_o    = 1'b1;
               op_d      = w_f3;
               rd_d      = RDaddr_i;
               acc_d     = {{XLEN{1'b0}}, w_mag1};
               opb_d     = w_mag2;
               neg_res_d = w_neg1 ^ w_neg2;
               neg_rem_d = w_neg1;
               cnt_d     = 5'd0;
               if (w_div0) begin
                  state_d  = S_DONE;
                  result_d = w_f3[1] ? data1_i : {XLEN{1'b1}};
                  rdout_d  = RDaddr_i;
               end else if (w_ovf) begin
                  state_d  = S_DONE;
                  result_d = w_f3[1] ? {XLEN{1'b0}} : w_min;
                  rdout_d  = RDaddr_i;
               end else begin
                  state_d  = w_f3[2] ? S_DIV : S_MUL;
               end
            end
         end
         S_MUL: begin
            busy_o = 1'b1;
            acc_d  = w_mul_next;
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d  = S_DONE;
               result_d = w_mul_res;
               rdout_d  = rd_q;
            end
         end
         S_DIV: begin
            busy_o = 1'b1;
            acc_d  = w_div_next;
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d  = S_DONE;
               result_d = w_div_res;
               rdout_d  = rd_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // A flushed op never completes and leaves the visible result untouched.
      if (flush_i) begin
         state_d  = S_IDLE;
         cnt_d    = 5'd0;
         result_d = result_q;
         rdout_d  = rdout_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         acc_q     <= '0;
         opb_q     <= '0;
         cnt_q     <= 5'd0;
         op_q      <= 3'b000;
         rd_q      <= 5'd0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
         rdout_q   <= 5'd0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         opb_q     <= opb_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         rd_q      <= rd_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
         rdout_q   <= rdout_d;
      end
   end

   assign done_o   = (state_q == S_DONE);
   assign result_o = result_q;
   assign RDaddr_o = rdout_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_ex_muldiv_unit: directed + random bench for ex_muldiv_unit           |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module tb_ex_muldiv_unit;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [9:0]  funct_i = '0;
   logic [31:0] data1_i = '0;
   logic [31:0] data2_i = '0;
   logic [4:0]  RDaddr_i = '0;
   logic        busy_o, done_o;
   logic [31:0] result_o;
   logic [4:0]  RDaddr_o;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_res = '0;

   ex_muldiv_unit #(.XLEN(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .flush_i(flush_i),
      .funct_i(funct_i), .data1_i(data1_i), .data2_i(data2_i), .RDaddr_i(RDaddr_i),
      .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .RDaddr_o(RDaddr_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: RV32M semantics from plain 64-bit arithmetic.
   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'b0, a};
      ub = {32'b0, b};
      p = '0;
      case (f3)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
            p = sa / sb; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFFFFFF;
            p = ua / ub; return p[31:0];
         end
         3'd6: begin
            if (b == 0) return a;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            p = ua % ub; return p[31:0];
         end
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      return f3[2] && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
   endfunction

   // Holds start_i through DONE (pipeline frozen, then still presenting the op).
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input string tag);
      int cyc, done_cyc, busy_cnt, extra;
      logic [31:0] res;
      logic [4:0]  rdo;
      bit spec;
      spec = is_special(f3, a, b);
      @(negedge clk_i);
      start_i = 1'b1; funct_i = {7'b0000001, f3}; data1_i = a; data2_i = b; RDaddr_i = rd;
      cyc = 0; done_cyc = -1; busy_cnt = 0; res = '0; rdo = '0;
      while (cyc <= 40) begin
         #1;
         if (busy_o) busy_cnt++;
         if (done_o) begin done_cyc = cyc; res = result_o; rdo = RDaddr_o; break; end
         @(negedge clk_i);
         cyc++;
      end
      check({tag, " done_cycle"}, done_cyc, spec ? 32'd1 : 32'd33);
      check({tag, " busy_cycles"}, busy_cnt, spec ? 32'd1 : 32'd33);
      check({tag, " result"}, res, exp);
      check({tag, " rdaddr"}, {27'b0, rdo}, {27'b0, rd});
      @(negedge clk_i);
      start_i = 1'b0;
      extra = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (done_o) extra++;
         @(negedge clk_i);
      end
      check({tag, " extra_done"}, extra, 32'd0);
      last_res = exp;
   endtask

   initial begin
      int dn;
      logic [2:0] f3;
      logic [31:0] a, b;
      int r;

      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      check("reset busy", {31'b0, busy_o}, 32'd0);
      check("reset done", {31'b0, done_o}, 32'd0);
      check("reset result", result_o, 32'd0);
      check("reset rdaddr", {27'b0, RDaddr_o}, 32'd0);

      run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd3, 32'hFFFFFFEB, "MUL 7*-3");
      run_op(3'd1, 32'h80000000, 32'h80000000, 5'd4, 32'h40000000, "MULH");
      run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'hFFFFFFFE, "MULHU");
      run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'hFFFFFFFF, "MULHSU");
      run_op(3'd4, 32'hFFFFFFF9, 32'd2, 5'd7, 32'hFFFFFFFD, "DIV -7/2");
      run_op(3'd6, 32'hFFFFFFF9, 32'd2, 5'd8, 32'hFFFFFFFF, "REM -7/2");
      run_op(3'd5, 32'd100, 32'd7, 5'd9, 32'd14, "DIVU 100/7");
      run_op(3'd7, 32'd100, 32'd7, 5'd10, 32'd2, "REMU 100/7");
      run_op(3'd5, 32'd5, 32'd0, 5'd11, 32'hFFFFFFFF, "DIVU 5/0");
      run_op(3'd6, 32'd5, 32'd0, 5'd12, 32'd5, "REM 5/0");
      run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, "DIV ovf");
      run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0, "REM ovf");

      // Flush at cycle 10 of a DIV.
      @(negedge clk_i);
      start_i = 1'b1; funct_i = {7'b0000001, 3'd4}; data1_i = 32'd1000; data2_i = 32'd3; RDaddr_i = 5'd20;
      repeat (10) @(negedge clk_i);
      flush_i = 1'b1;
      #1 check("flush cyc10 done", {31'b0, done_o}, 32'd0);
      @(negedge clk_i);
      flush_i = 1'b0; start_i = 1'b0;
      #1;
      check("flush idle busy", {31'b0, busy_o}, 32'd0);
      dn = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_i); #1;
         if (done_o) dn++;
      end
      check("flush no done", dn, 32'd0);
      check("flush result held", result_o, last_res);
      check("flush rdaddr held", {27'b0, RDaddr_o}, 32'd14);

      // flush_i beats a valid start in IDLE.
      @(negedge clk_i);
      start_i = 1'b1; flush_i = 1'b1; funct_i = {7'b0000001, 3'd0};
      #1 check("flush vs start busy", {31'b0, busy_o}, 32'd0);
      @(negedge clk_i);
      start_i = 1'b0; flush_i = 1'b0;
      #1 check("flush vs start done", {31'b0, done_o}, 32'd0);

      // Invalid funct7 is ignored.
      @(negedge clk_i);
      start_i = 1'b1; funct_i = {7'b0000000, 3'd0}; data1_i = 32'd3; data2_i = 32'd4;
      #1 check("bad funct7 busy", {31'b0, busy_o}, 32'd0);
      dn = 0;
      for (int i = 0; i < 36; i++) begin
         @(negedge clk_i); #1;
         if (done_o || busy_o) dn++;
      end
      start_i = 1'b0;
      check("bad funct7 activity", dn, 32'd0);

      for (int i = 0; i < 24; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a = $urandom;
         r = $urandom_range(0, 9);
         if (r == 0) b = 32'd0;
         else if (r == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
         else if (r == 2) b = 32'($urandom_range(1, 20));
         else b = $urandom;
         run_op(f3, a, b, 5'($urandom_range(0, 31)), ref_model(f3, a, b), $sformatf("rand%0d f3=%0d", i, f3));
      end

      // Reset mid-MUL clears every output.
      @(negedge clk_i);
      start_i = 1'b1; funct_i = {7'b0000001, 3'd0}; data1_i = 32'd9; data2_i = 32'd9; RDaddr_i = 5'd31;
      repeat (5) @(negedge clk_i);
      rst_i = 1'b1; start_i = 1'b0;
      @(negedge clk_i);
      #1;
      check("rst mid busy", {31'b0, busy_o}, 32'd0);
      check("rst mid done", {31'b0, done_o}, 32'd0);
      check("rst mid result", result_o, 32'd0);
      check("rst mid rdaddr", {27'b0, RDaddr_o}, 32'd0);
      rst_i = 1'b0;
      run_op(3'd0, 32'd9, 32'd9, 5'd31, 32'd81, "MUL after rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
